// File: rtl/signed_stream_extrema_pkg.sv
// Shared types and defaults for the signed stream extrema block.
package signed_stream_extrema_pkg;

    // Frame FSM: accumulate samples, then hold the result until it is taken.
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int DEF_W  = 4;
    localparam int DEF_CW = 8;

endpackage

// File: rtl/signed_stream_extrema_gt_cmp.sv
// Combinational signed a > b for W-bit two's-complement operands.
// The sign bits are compared first. When the signs match, the lower bits
// are compared as unsigned magnitudes, which orders both halves correctly.
module signed_gt_cmp #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         gt_o
);

    // If the signs differ, a is larger exactly when a is non-negative.
    always_comb begin
        if (a_i[W-1] != b_i[W-1]) gt_o = ~a_i[W-1];
        else                      gt_o = (a_i[W-2:0] > b_i[W-2:0]);
    end

endmodule

// File: rtl/signed_stream_extrema.sv
// Per-frame signed max/min/argmax/count over a valid/ready sample stream.
// The result for each frame is registered and is held until it is taken.
// Optional macro SIGNED_STREAM_EXTREMA_MIN_EN enables minimum tracking.
// When the macro is not defined, out_min is tied to 0.
module signed_stream_extrema
    import signed_stream_extrema_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_max,
    output logic [W-1:0]  out_min,
    output logic [CW-1:0] out_max_idx,
    output logic [CW-1:0] out_count,
    output logic          out_ovf
);

    state_e        state_q, state_d;
    logic [W-1:0]  max_q, max_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          gt_max;
    logic          in_xfer, out_xfer, first, sat;

    assign in_xfer  = (state_q == ACC) && in_valid;
    assign out_xfer = (state_q == HOLD) && out_ready;
    assign first    = (cnt_q == '0);
    assign sat      = (cnt_q == '1);

    signed_gt_cmp #(.W(W)) u_gt_max (
        .a_i  (in_data),
        .b_i  (max_q),
        .gt_o (gt_max)
    );

    // Next state and next accumulator values for max, index, count and overflow.
    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (in_xfer) begin
            if (first) begin
                max_d = in_data;
                idx_d = '0;
                cnt_d = CW'(1);
            end else begin
                // A saturated count cannot name a position, so the index freezes.
                if (sat) ovf_d = 1'b1;
                else     cnt_d = cnt_q + CW'(1);
                if (gt_max) begin
                    max_d = in_data;
                    if (!sat) idx_d = cnt_q;
                end
            end
            if (in_last) state_d = HOLD;
        end else if (out_xfer) begin
            state_d = ACC;
            max_d   = '0;
            idx_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    // State and accumulator registers. A reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ACC;
            max_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef SIGNED_STREAM_EXTREMA_MIN_EN
    logic [W-1:0] min_q, min_d;
    logic         lt_min;

    // min > data is the same comparison as for max, with the operands swapped.
    signed_gt_cmp #(.W(W)) u_gt_min (
        .a_i  (min_q),
        .b_i  (in_data),
        .gt_o (lt_min)
    );

    // Next minimum. It follows the same frame start and release rules as max.
    always_comb begin
        min_d = min_q;
        if (in_xfer) begin
            if (first || lt_min) min_d = in_data;
        end else if (out_xfer) begin
            min_d = '0;
        end
    end

    // Minimum register.
    always_ff @(posedge clk) begin
        if (!reset_n) min_q <= '0;
        else          min_q <= min_d;
    end

    assign out_min = min_q;
`else
    assign out_min = '0;
`endif

    assign in_ready    = (state_q == ACC);
    assign out_valid   = (state_q == HOLD);
    assign out_max     = max_q;
    assign out_max_idx = idx_q;
    assign out_count   = cnt_q;
    assign out_ovf     = ovf_q;

endmodule

// File: tb/tb_signed_stream_extrema.sv
// Directed bench for signed_stream_extrema. Two instances share all inputs.
// The CW=8 instance covers the normal frame cases.
// The CW=2 instance covers counter saturation.
module tb_signed_stream_extrema;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b0;

    logic         in_ready, out_valid, out_ovf;
    logic [W-1:0] out_max, out_min;
    logic [7:0]   out_max_idx, out_count;

    logic         in_ready2, out_valid2, out_ovf2;
    logic [W-1:0] out_max2, out_min2;
    logic [1:0]   out_max_idx2, out_count2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    signed_stream_extrema #(.W(W), .CW(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_max(out_max), .out_min(out_min),
        .out_max_idx(out_max_idx), .out_count(out_count), .out_ovf(out_ovf)
    );

    signed_stream_extrema #(.W(W), .CW(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
        .out_ready(out_ready), .out_max(out_max2), .out_min(out_min2),
        .out_max_idx(out_max_idx2), .out_count(out_count2), .out_ovf(out_ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sw(input int v);
        logic [W-1:0] t;
        t = W'(v);
        return 32'(t);
    endfunction

    function automatic logic [31:0] exp_min(input int v);
`ifdef SIGNED_STREAM_EXTREMA_MIN_EN
        return sw(v);
`else
        return (v == 12345) ? 32'd1 : 32'd0;
`endif
    endfunction

    // Present one sample and wait, with a bound, until it is accepted.
    task automatic send(input int v, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = W'(v);
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for a result, compare every field, then take the result.
    task automatic expect_res(input string tag, input int mx, input int mn,
                              input int ix, input int cn, input int ov);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_max"},   32'(out_max), sw(mx));
        chk({tag, "_min"},   32'(out_min), exp_min(mn));
        chk({tag, "_idx"},   32'(out_max_idx), 32'(ix));
        chk({tag, "_count"}, 32'(out_count), 32'(cn));
        chk({tag, "_ovf"},   32'(out_ovf), 32'(ov));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_released"}, 32'(out_valid), 0);
        chk({tag, "_ready_back"}, 32'(in_ready), 1);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready",  32'(in_ready), 1);
        chk("rst_max",       32'(out_max), 0);
        chk("rst_min",       32'(out_min), 0);
        chk("rst_count",     32'(out_count), 0);
        chk("rst_ovf",       32'(out_ovf), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame. The result becomes valid right after the last transfer.
        send(3, 0); send(-2, 0); send(7, 0);
        chk("basic_not_yet", 32'(out_valid), 0);
        send(-8, 1);
        chk("basic_latency", 32'(out_valid), 1);
        chk("basic_in_ready_low", 32'(in_ready), 0);
        expect_res("basic", 7, -8, 2, 4, 0);

        // Frame with a single sample.
        send(-1, 1);
        expect_res("single", -1, -1, 0, 1, 0);

        // Ties keep the first occurrence. Both sign extremes appear.
        send(5, 0); send(-8, 0); send(5, 0); send(7, 0); send(7, 1);
        expect_res("ties", 7, -8, 3, 5, 0);

        // Backpressure: the result holds still and input is stalled.
        send(2, 0); send(-3, 1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_valid",    32'(out_valid), 1);
            chk("bp_max",      32'(out_max), sw(2));
            chk("bp_min",      32'(out_min), exp_min(-3));
            chk("bp_count",    32'(out_count), 2);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_one_xfer", 32'(out_valid), 0);
        chk("bp_cleared",  32'(out_count), 0);
        send(0, 1);
        expect_res("bp_next", 0, 0, 0, 1, 0);

        // Counter saturation on the CW=2 instance.
        send(1, 0); send(2, 0); send(3, 0); send(4, 0); send(-1, 1);
        chk("ovf2_valid", 32'(out_valid2), 1);
        chk("ovf2_count", 32'(out_count2), 3);
        chk("ovf2_ovf",   32'(out_ovf2), 1);
        chk("ovf2_max",   32'(out_max2), sw(4));
        chk("ovf2_idx",   32'(out_max_idx2), 2);
        chk("ovf2_min",   32'(out_min2), exp_min(-1));
        expect_res("ovf_wide", 4, -1, 3, 5, 0);
        chk("ovf2_released", 32'(out_ovf2), 0);

        // Reset in the middle of a frame discards the partial frame.
        send(6, 0); send(6, 0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_count", 32'(out_count), 0);
        send(-3, 1);
        expect_res("midrst", -3, -3, 0, 1, 0);

        // A reset during the hold phase drops the result.
        send(1, 1);
        chk("holdrst_pre", 32'(out_valid), 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("holdrst_valid", 32'(out_valid), 0);
        chk("holdrst_max",   32'(out_max), 0);

        // in_last without in_valid has no effect.
        in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_last = 1'b0;
        chk("last_novalid", 32'(out_valid), 0);
        send(-5, 0); send(-6, 1);
        expect_res("after_stray_last", -5, -6, 0, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
